// File: rtl/gc_mem_initiator.sv
// Host-side initiator for the 8-bank gain-cell DRAM controller: single-word host
// read/write over valid/ready, plus a background read/write-back refresh sweep.
module gc_mem_initiator #(
    parameter int unsigned ADDR_W           = 10,
    parameter int unsigned DATA_W           = 64,
    parameter int unsigned REFRESH_INTERVAL = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              ref_active
);

    localparam int unsigned CNT_W = (REFRESH_INTERVAL > 2) ? $clog2(REFRESH_INTERVAL) : 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);
    localparam logic [CNT_W-1:0] CNT_ARM  = CNT_W'(REFRESH_INTERVAL - 2);

    typedef enum logic [1:0] {
        IDLE,
        REF_RD,
        REF_WB
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  ref_cnt;
    logic [ADDR_W-1:0] ref_addr;
    logic              ref_pending;
    logic              rd_inflight;
    logic              host_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ref_cnt     <= '0;
            ref_addr    <= '0;
            ref_pending <= 1'b0;
            rd_inflight <= 1'b0;
        end else begin
            state       <= state_nxt;
            rd_inflight <= host_rd;
            ref_cnt     <= (ref_cnt == CNT_LAST) ? '0 : ref_cnt + CNT_W'(1);
            // Armed one count early so ref_pending is high while ref_cnt == REFRESH_INTERVAL-1
            if (ref_cnt == CNT_ARM)
                ref_pending <= 1'b1;
            else if (state == IDLE && ref_pending)
                ref_pending <= 1'b0;
            if (state == REF_WB)
                ref_addr <= ref_addr + ADDR_W'(1);
        end
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        host_rd    = 1'b0;
        rsp_valid  = 1'b0;
        rsp_rdata  = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_waddr  = '0;
        mem_raddr  = '0;
        mem_in     = '0;
        ref_active = 1'b0;
        // Everything is held at zero while reset is asserted
        if (!rst) begin
            rsp_valid = rd_inflight;
            if (rd_inflight)
                rsp_rdata = mem_rd;
            case (state)
                IDLE: begin
                    req_ready = !ref_pending;
                    if (ref_pending)
                        state_nxt = REF_RD;
                    if (req_valid && !ref_pending) begin
                        if (req_we) begin
                            mem_we    = 1'b1;
                            mem_waddr = req_addr;
                            mem_in    = req_wdata;
                        end else begin
                            mem_re    = 1'b1;
                            mem_raddr = req_addr;
                            host_rd   = 1'b1;
                        end
                    end
                end
                REF_RD: begin
                    ref_active = 1'b1;
                    mem_re     = 1'b1;
                    mem_raddr  = ref_addr;
                    state_nxt  = REF_WB;
                end
                REF_WB: begin
                    ref_active = 1'b1;
                    mem_we     = 1'b1;
                    mem_waddr  = ref_addr;
                    mem_in     = mem_rd;
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gc_mem_initiator.sv
// Scoreboard bench for gc_mem_initiator with a 1-cycle-latency bank model.
module tb_gc_mem_initiator;

    localparam int RI = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [9:0]  req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic [63:0] rsp_rdata;
    logic        mem_we;
    logic        mem_re;
    logic [9:0]  mem_waddr;
    logic [9:0]  mem_raddr;
    logic [63:0] mem_in;
    logic [63:0] mem_rd = '0;
    logic        ref_active;

    logic [63:0] bank   [1024];
    logic [63:0] shadow [1024];
    logic [63:0] exp_q  [$];

    int          n_chk = 0;
    int          n_fail = 0;
    int          n_ref = 0;
    int          n_wb = 0;
    int          wraps = 0;
    logic [9:0]  exp_ref = '0;
    logic [9:0]  last_ref_raddr = '0;

    gc_mem_initiator #(
        .ADDR_W(10),
        .DATA_W(64),
        .REFRESH_INTERVAL(RI)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
        .mem_in(mem_in), .mem_rd(mem_rd), .ref_active(ref_active)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input logic [9:0] a);
        return {a, 22'h155555, 16'hBEEF, 6'h00, a};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Controller bank model: read data appears the cycle after mem_re
    always @(posedge clk) begin
        if (mem_re) mem_rd <= bank[mem_raddr];
        if (mem_we) bank[mem_waddr] <= mem_in;
    end

    always @(posedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_ref = '0;
        end
    end

    // Monitor: response scoreboard, refresh address sequence, strobe exclusivity
    always @(negedge clk) begin
        check("we_re_exclusive", {63'd0, mem_we & mem_re}, 64'd0);
        if (rsp_valid) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                check("rsp_data", rsp_rdata, exp_q.pop_front());
            end
        end else begin
            check("rsp_idle_zero", rsp_rdata, 64'd0);
        end
        if (ref_active && mem_re) begin
            check("ref_raddr", {54'd0, mem_raddr}, {54'd0, exp_ref});
            last_ref_raddr = mem_raddr;
            n_ref++;
        end
        if (ref_active && mem_we) begin
            check("ref_waddr", {54'd0, mem_waddr}, {54'd0, exp_ref});
            check("ref_wdata", mem_in, shadow[exp_ref]);
            if (exp_ref == 10'd1023) wraps++;
            exp_ref = exp_ref + 10'd1;
            n_wb++;
        end
    end

    task automatic issue(input logic we, input logic [9:0] a, input logic [63:0] d);
        int unsigned n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        @(negedge clk);
        while (!req_ready && n < 10) begin
            n++;
            @(negedge clk);
        end
        if (!req_ready) begin
            check("issue_ready_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        if (we) begin
            check("wr_we", {63'd0, mem_we}, 64'd1);
            check("wr_addr", {54'd0, mem_waddr}, {54'd0, a});
            check("wr_data", mem_in, d);
            shadow[a] = d;
        end else begin
            check("rd_re", {63'd0, mem_re}, 64'd1);
            check("rd_addr", {54'd0, mem_raddr}, {54'd0, a});
            exp_q.push_back(shadow[a]);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    endtask

    task automatic wait_refs(input int target);
        int unsigned n = 0;
        while (n_ref < target && n < 4 * RI) begin
            n++;
            @(posedge clk);
        end
        #1;
        if (n_ref < target) check("ref_timeout", 64'd0, 64'd1);
    endtask

    task automatic sync_after_refresh();
        int wb0 = n_wb;
        int unsigned n = 0;
        while (n_wb == wb0 && n < 4 * RI) begin
            n++;
            @(posedge clk);
        end
        #1;
        if (n_wb == wb0) check("wb_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [9:0] b2b [4];
        int run;
        bit seen_ready;
        b2b[0] = 10'h000; b2b[1] = 10'h080; b2b[2] = 10'h100; b2b[3] = 10'h380;
        for (int i = 0; i < 1024; i++) begin
            bank[i]   = pat(10'(i));
            shadow[i] = pat(10'(i));
        end

        // Reset with a request presented
        rst = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 10'h005; req_wdata = '1;
        @(posedge clk); @(negedge clk);
        check("rst_ready", {63'd0, req_ready}, 64'd0);
        check("rst_we_re", {62'd0, mem_we, mem_re}, 64'd0);
        check("rst_addrs", {44'd0, mem_waddr, mem_raddr}, 64'd0);
        check("rst_in", mem_in, 64'd0);
        check("rst_rsp", {63'd0, rsp_valid}, 64'd0);
        check("rst_ref_active", {63'd0, ref_active}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle();

        // First refresh timing, idle bus; cycle 0 is the first cycle after reset
        for (int n = 0; n <= RI + 2; n++) begin
            @(negedge clk);
            check("seq_ready", {63'd0, req_ready}, {63'd0, !(n >= RI - 1 && n <= RI + 1)});
            check("seq_active", {63'd0, ref_active}, {63'd0, (n == RI || n == RI + 1)});
            if (n == RI) begin
                check("seq_rd_strobes", {62'd0, mem_we, mem_re}, 64'd1);
                check("seq_rd_addr", {54'd0, mem_raddr}, 64'd0);
            end
            if (n == RI + 1) begin
                check("seq_wb_strobes", {62'd0, mem_we, mem_re}, 64'd2);
                check("seq_wb_addr", {54'd0, mem_waddr}, 64'd0);
                check("seq_wb_data", mem_in, pat(10'd0));
            end
        end
        @(posedge clk); #1;
        wait_refs(2);
        check("second_ref_addr", {54'd0, last_ref_raddr}, 64'd1);

        // Write/read round trip then back-to-back reads, starting right after a refresh
        sync_after_refresh();
        issue(1'b1, 10'h3A5, 64'hDEADBEEF_0000_0001);
        issue(1'b0, 10'h3A5, '0);
        idle();
        req_valid = 1'b1; req_we = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            if (i < 4) req_addr = b2b[i];
            else idle();
            @(negedge clk);
            if (i > 0) check("b2b_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            if (i < 4) begin
                check("b2b_ready", {63'd0, req_ready}, 64'd1);
                exp_q.push_back(shadow[b2b[i]]);
            end
            @(posedge clk); #1;
        end

        // Continuous reads across refreshes: each stall is exactly 3 cycles
        run = 0; seen_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0;
        for (int i = 0; i < 4 * RI; i++) begin
            req_addr = 10'((i * 37) % 1024);
            @(negedge clk);
            if (req_ready) begin
                if (seen_ready && run != 0) check("stall_len", 64'(run), 64'd3);
                run = 0;
                seen_ready = 1'b1;
                exp_q.push_back(shadow[req_addr]);
            end else begin
                run++;
            end
            @(posedge clk); #1;
        end
        idle();

        // Let the sweep wrap from 1023 back to 0
        for (int n = 0; n < 1100 * RI && wraps == 0; n++) @(posedge clk);
        #1;
        check("sweep_wrapped", 64'(wraps), 64'd1);
        wait_refs(n_ref + 1);
        check("wrap_ref_addr", {54'd0, last_ref_raddr}, 64'd0);

        // Data survives the full sweep
        sync_after_refresh();
        issue(1'b0, 10'h3A5, '0);
        issue(1'b0, 10'h080, '0);
        idle();

        // Reset during REF_RD
        for (int n = 0; n < 4 * RI && !(ref_active && mem_re); n++) @(negedge clk);
        check("found_ref_rd", {63'd0, ref_active & mem_re}, 64'd1);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midref_no_we", {63'd0, mem_we}, 64'd0);
        check("midref_idle", {62'd0, ref_active, req_ready}, 64'd1);
        wait_refs(n_ref + 1);
        check("midref_ref_addr", {54'd0, last_ref_raddr}, 64'd0);

        // Reset with a read in flight drops the response
        sync_after_refresh();
        issue(1'b0, 10'h100, '0);
        idle();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("inflight_dropped", {63'd0, rsp_valid}, 64'd0);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
